write_buffer_ctrl: RTL and testbench

WRITE_BUFFER_CTRL -- requirements
Module: write_buffer_ctrl

---
 rtl/wbuf_pkg.sv | 16 +
 rtl/wbuf_fifo.sv | 57 +++++
 rtl/write_buffer_ctrl.sv | 143 ++++++++++++++
 tb/tb_write_buffer_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared types and constants for the write-buffer controller.
//   wb_state_e : controller FSM states
//   WORD_OFS   : byte-offset bits within a 4-byte word (forced to zero on mem_addr)
package wbuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    RESP
  } wb_state_e;

  localparam int WORD_OFS = 2;

endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: synchronous FIFO holding buffered write-through stores.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   push_i, din_i       : enqueue request and entry
//   pop_i, dout_o       : dequeue request and head entry (valid when !empty_o)
//   full_o, empty_o     : occupancy flags
//   count_o             : number of entries held (0..DEPTH)
module wbuf_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/write_buffer_ctrl.sv
// write_buffer_ctrl: write-through store buffer in front of backing memory.
// Stores are queued in a FIFO and drained one at a time; a miss-fill read is
// only accepted when the buffer is empty, so it always sees earlier stores.
// Ports:
//   clk, reset                                : clock, async active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data         : store stream from the cache
//   rd_valid/rd_ready/rd_addr                 : miss-fill request
//   rd_resp_valid/rd_resp_data                : fill data back to the cache
//   mem_req_valid/mem_req_ready/mem_we/
//   mem_addr/mem_wdata                        : backing-memory request
//   mem_resp_valid/mem_rdata                  : backing-memory read return
module write_buffer_ctrl
  import wbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    {{(ADDR_WIDTH-WORD_OFS){1'b1}}, {WORD_OFS{1'b0}}};

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  buf_push, buf_pop, buf_full, buf_empty;
  logic [CW-1:0]         buf_count;
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign {head_addr, head_data} = head;

  // Store acceptance is independent of the FSM; a full buffer never bypasses.
  assign wr_ready = !buf_full;
  assign buf_push = wr_valid && wr_ready;
  assign buf_pop  = (state_q == WR) && mem_req_ready;
  assign rd_ready = (state_q == IDLE) && buf_empty;

  wbuf_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .din_i   ({wr_addr, wr_data}),
    .pop_i   (buf_pop),
    .dout_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next state. A read wins over draining only when the buffer is empty, so a
  // store accepted in the same cycle as the read is ordered after it.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_valid && buf_empty) begin
          rd_addr_d = rd_addr;
          state_d   = RD_REQ;
        end else if (!buf_empty) begin
          state_d = WR;
        end
      end
      WR:      if (mem_req_ready) state_d = IDLE;
      RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rd_resp_valid = 1'b0;
    case (state_q)
      WR: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = head_addr & WORD_MASK;
        mem_wdata     = head_data;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = rd_addr_q & WORD_MASK;
      end
      RESP:    rd_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rd_resp_data = rdata_q;

  a_fifo_flags: assert property (@(posedge clk) disable iff (reset)
    (buf_full == (buf_count == CW'(DEPTH))) && (buf_empty == (buf_count == '0)));

endmodule

// File: tb/tb_write_buffer_ctrl.sv
module tb_write_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [31:0] rd_addr = '0;
  logic        rd_resp_valid;
  logic [31:0] rd_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_resp_cyc = 0;
  int          rd_delay = 0;
  logic [31:0] rd_data_cfg = '0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mtx_t;

  mtx_t        mem_q[$];
  logic [31:0] rd_q[$];

  write_buffer_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: memory requests and fill responses checked as they occur.
  always @(negedge clk) begin : mon
    mtx_t e;
    if (!reset) begin
      if (mem_resp_valid) last_resp_cyc = cyc;
      if (mem_req_valid && mem_req_ready) begin
        check("mem_req_expected", mem_q.size() != 0, 1);
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.data);
          if (mem_we) check("wr_after_read", rd_q.size(), 0);
        end
      end
      if (rd_resp_valid) begin
        check("rd_resp_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          check("rd_resp_data", rd_resp_data, rd_q.pop_front());
          check("rd_latency", cyc - last_resp_cyc, 1);
        end
      end
    end
  end

  // Backing-memory read responder: returns rd_data_cfg rd_delay cycles after accept.
  always begin
    @(negedge clk);
    if (!reset && mem_req_valid && mem_req_ready && !mem_we) begin
      @(posedge clk);
      repeat (rd_delay) @(posedge clk);
      #1;
      mem_resp_valid = 1'b1;
      mem_rdata      = rd_data_cfg;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'hDEAD_BEEF;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_a);
    bit ok = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1; break; end
    end
    check("wr_accept", ok, 1);
    if (ok) mem_q.push_back(mtx_t'{1'b1, exp_a, d});
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_a, input logic [31:0] d);
    bit ok = 0;
    rd_valid = 1'b1; rd_addr = a; rd_data_cfg = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_ready) begin ok = 1; break; end
    end
    check("rd_accept", ok, 1);
    if (ok) begin
      mem_q.push_back(mtx_t'{1'b0, exp_a, 32'h0});
      rd_q.push_back(d);
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_q.size() == 0 && rd_q.size() == 0) break;
    end
    check("drain_done", mem_q.size() + rd_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n_req;
    int n_resp;

    // Asynchronous reset: outputs cleared before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_rd_resp_valid", rd_resp_valid, 0);
    check("rst_rd_resp_data", rd_resp_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 1);
    @(posedge clk); #1;

    // Two writes drain in order; first issued one cycle after it is buffered.
    mem_req_ready = 1'b1;
    do_write(32'h10, 32'h11, 32'h10);
    @(negedge clk);
    check("idle_before_wr", mem_req_valid, 0);
    @(negedge clk);
    check("wr_issue", mem_req_valid, 1);
    @(posedge clk); #1;
    do_write(32'h14, 32'h22, 32'h14);
    wait_drain();

    // Fill the buffer with memory stalled; fifth write held until a pop.
    mem_req_ready = 1'b0;
    do_write(32'h40, 32'hA0, 32'h40);
    do_write(32'h44, 32'hA1, 32'h44);
    do_write(32'h48, 32'hA2, 32'h48);
    do_write(32'h4C, 32'hA3, 32'h4C);
    @(negedge clk);
    check("full_ready_low", wr_ready, 0);
    wr_valid = 1'b1; wr_addr = 32'h50; wr_data = 32'hA4;
    repeat (3) @(negedge clk);
    check("full_hold", wr_ready, 0);
    @(posedge clk); #1 mem_req_ready = 1'b1;
    @(negedge clk);
    check("no_bypass", wr_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_pop", wr_ready, 1);
    mem_q.push_back(mtx_t'{1'b1, 32'h50, 32'hA4});
    @(posedge clk); #1 wr_valid = 1'b0;
    wait_drain();

    // Read behind a buffered write to the same address.
    mem_req_ready = 1'b0;
    do_write(32'h20, 32'h55, 32'h20);
    rd_valid = 1'b1; rd_addr = 32'h20;
    repeat (3) @(negedge clk);
    check("rd_blocked", rd_ready, 0);
    @(posedge clk); #1 mem_req_ready = 1'b1;
    do_read(32'h20, 32'h20, 32'hABCD);
    wait_drain();
    @(negedge clk);
    check("resp_pulse_once", rd_resp_valid, 0);
    check("resp_data_hold", rd_resp_data, 32'hABCD);
    @(posedge clk); #1;

    // Unaligned store address is word-aligned on the memory side.
    do_write(32'h23, 32'h77, 32'h20);
    wait_drain();

    // Simultaneous read and write with empty buffer: read goes first.
    rd_valid = 1'b1; rd_addr = 32'h30; rd_data_cfg = 32'h1234;
    wr_valid = 1'b1; wr_addr = 32'h34; wr_data = 32'h99;
    @(negedge clk);
    check("sim_rd_ready", rd_ready, 1);
    check("sim_wr_ready", wr_ready, 1);
    mem_q.push_back(mtx_t'{1'b0, 32'h30, 32'h0});
    rd_q.push_back(32'h1234);
    mem_q.push_back(mtx_t'{1'b1, 32'h34, 32'h99});
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_valid = 1'b0;
    wait_drain();

    // Write during a slow read drains only after the response.
    rd_delay = 5;
    do_read(32'h60, 32'h60, 32'h0BAD_F00D);
    repeat (2) @(posedge clk); #1;
    do_write(32'h64, 32'h66, 32'h64);
    @(negedge clk);
    check("rd_wait_no_wr", mem_req_valid, 0);
    @(posedge clk); #1;
    wait_drain();

    // Reset during RD_WAIT with two buffered writes.
    rd_delay = 20;
    do_read(32'h80, 32'h80, 32'h5A5A);
    do_write(32'h84, 32'hB4, 32'h84);
    do_write(32'h88, 32'hB8, 32'h88);
    check("pre_rst_resp_data", rd_resp_data, 32'h0BAD_F00D);
    reset = 1'b1;
    #1;
    mem_q.delete();
    rd_q.delete();
    check("midrst_mem_req_valid", mem_req_valid, 0);
    check("midrst_rd_resp_data", rd_resp_data, 0);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_rd_ready", rd_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_req = 0;
    n_resp = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_req_valid) n_req++;
      if (rd_resp_valid) n_resp++;
    end
    check("post_rst_no_req", n_req, 0);
    check("post_rst_no_resp", n_resp, 0);
    check("post_rst_rd_ready", rd_ready, 1);
    check("post_rst_resp_data", rd_resp_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
